// File: rtl/shiftreg_sequencer.sv
// shiftreg_sequencer: drives a 4-bit universal shift register to serialize one word LSB- or MSB-first.
// Define SHIFTREG_SEQ_ROTATE_EN to refill the register from its own outgoing bit (rotate).
module shiftreg_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       dir,
  input  logic       valid,
  output logic       ready,
  input  logic       stall,
  input  logic [3:0] q,
  output logic [1:0] mode,
  output logic [3:0] in,
  output logic       rightshift,
  output logic       leftshift,
  output logic       serial_out,
  output logic       serial_valid,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t     state;
  logic [1:0] cnt;
  logic [3:0] word;
  logic       dir_r;
  logic       shifting;
  logic       unused;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
      dir_r <= 1'b0;
    end else
      case (state)
        IDLE: if (valid) begin
          word  <= data_in;
          dir_r <= dir;
          state <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: if (!stall) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
  assign shifting     = state == SHIFT && !stall;
  assign ready        = state == IDLE;
  assign done         = state == DONE;
  assign in           = word;
  assign mode         = state == LOAD ? 2'b11 : shifting ? (dir_r ? 2'b10 : 2'b01) : 2'b00;
  assign serial_valid = shifting;
  assign serial_out   = shifting && (dir_r ? q[3] : q[0]);
  assign unused       = ^q[2:1];
`ifdef SHIFTREG_SEQ_ROTATE_EN
  assign rightshift = state == SHIFT && q[0];
  assign leftshift  = state == SHIFT && q[3];
`else
  assign rightshift = 1'b0;
  assign leftshift  = 1'b0;
`endif
endmodule

// File: tb/tb_shiftreg_sequencer.sv
// tb_shiftreg_sequencer: self-checking bench with a transaction-level model and an attached shift register.
module tb_shiftreg_sequencer;
  logic       clk = 0;
  logic       reset = 0;
  logic [3:0] data_in = 0;
  logic       dir = 0;
  logic       valid = 0;
  logic       ready;
  logic       stall = 0;
  logic [3:0] q = 0;
  logic [1:0] mode;
  logic [3:0] in;
  logic       rightshift, leftshift, serial_out, serial_valid, done;
  int n_chk = 0;
  int n_fail = 0;
`ifdef SHIFTREG_SEQ_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  shiftreg_sequencer dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dir(dir), .valid(valid), .ready(ready),
    .stall(stall), .q(q), .mode(mode), .in(in), .rightshift(rightshift), .leftshift(leftshift),
    .serial_out(serial_out), .serial_valid(serial_valid), .done(done)
  );

  always #5 clk = ~clk;

  // downstream universal shift register
  always @(posedge clk)
    case (mode)
      2'b01: q <= {rightshift, q[3:1]};
      2'b10: q <= {q[2:0], leftshift};
      2'b11: q <= in;
      default: q <= q;
    endcase

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // transaction model: phase of the current word plus the bits still owed
  typedef enum {P_IDLE, P_LOAD, P_BITS, P_DONE} phase_t;
  phase_t     ph = P_IDLE;
  logic [3:0] m_word = 0;
  logic       m_dir = 0;
  bit         owed[$];

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ready", ready, 1);
      chk("rst_mode", mode, 0);
      chk("rst_in", in, 0);
      chk("rst_done", done, 0);
      chk("rst_sv", serial_valid, 0);
      chk("rst_rs", rightshift, 0);
      chk("rst_ls", leftshift, 0);
      ph = P_IDLE;
      m_word = 0;
      m_dir = 0;
      owed.delete();
    end else begin
      chk("in_word", in, m_word);
      chk("ready", ready, ph == P_IDLE);
      chk("done", done, ph == P_DONE);
      case (ph)
        P_IDLE: begin
          chk("idle_mode", mode, 0);
          chk("idle_sv", serial_valid, 0);
          if (valid) begin
            m_word = data_in;
            m_dir = dir;
            for (int i = 0; i < 4; i++) owed.push_back(dir ? data_in[3-i] : data_in[i]);
            ph = P_LOAD;
          end
        end
        P_LOAD: begin
          chk("load_mode", mode, 3);
          chk("load_sv", serial_valid, 0);
          ph = P_BITS;
        end
        P_BITS: begin
          if (stall) begin
            chk("stall_mode", mode, 0);
            chk("stall_sv", serial_valid, 0);
          end else begin
            chk("shift_mode", mode, m_dir ? 2 : 1);
            chk("shift_sv", serial_valid, 1);
            chk("serial_bit", serial_out, owed.pop_front());
            chk("rs_fill", rightshift, ROT & q[0]);
            chk("ls_fill", leftshift, ROT & q[3]);
            if (owed.size() == 0) ph = P_DONE;
          end
        end
        P_DONE: begin
          chk("done_mode", mode, 0);
          chk("done_sv", serial_valid, 0);
          chk("done_q", q, ROT ? m_word : 4'b0000);
          ph = P_IDLE;
        end
      endcase
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) return;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [3:0] w, input logic d, input int stall_after, input int stall_len,
                      input int abort_after, input bit junk,
                      output logic [3:0] bits, output int lat, output logic [3:0] qa);
    int  nb = 0;
    int  ns = 0;
    bit  fin = 0;
    bits = 0;
    lat = 0;
    qa = 0;
    wait_ready();
    @(posedge clk); #1;
    data_in = w;
    dir = d;
    valid = 1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      valid = junk && nb < 4;
      data_in = junk ? 4'hf : w;
      stall = nb == stall_after && ns < stall_len;
      if (stall) ns++;
      if (nb == abort_after) begin
        reset = 0;
        #1;
        chk("async_ready", ready, 1);
        chk("async_mode", mode, 0);
        chk("async_done", done, 0);
        chk("async_sv", serial_valid, 0);
        @(posedge clk); #1;
        reset = 1;
        fin = 1;
        break;
      end
      @(negedge clk);
      if (serial_valid) begin
        bits = {bits[2:0], serial_out};
        nb++;
      end
      if (done) begin
        lat = k;
        qa = q;
        fin = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!fin) chk("done_timeout", 0, 1);
    valid = 0;
    stall = 0;
  endtask

  logic [3:0] bits, qa;
  int lat;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1;
    send(4'b1011, 0, 9, 0, 9, 0, bits, lat, qa);
    chk("lsb_bits", bits, 4'b1101);
    chk("lsb_lat", lat, 6);
    chk("lsb_q", qa, ROT ? 4'b1011 : 4'b0000);
    send(4'b1011, 1, 9, 0, 9, 0, bits, lat, qa);
    chk("msb_bits", bits, 4'b1011);
    chk("msb_lat", lat, 6);
    chk("msb_q", qa, ROT ? 4'b1011 : 4'b0000);
    send(4'b1011, 0, 2, 2, 9, 0, bits, lat, qa);
    chk("stall_bits", bits, 4'b1101);
    chk("stall_lat", lat, 8);
    send(4'b0101, 1, 9, 0, 9, 1, bits, lat, qa);
    chk("junk_bits", bits, 4'b0101);
    send(4'b0011, 0, 9, 0, 9, 0, bits, lat, qa);
    chk("after_junk_bits", bits, 4'b1100);
    send(4'b1011, 0, 9, 0, 2, 0, bits, lat, qa);
    send(4'b0110, 0, 9, 0, 9, 0, bits, lat, qa);
    chk("post_rst_bits", bits, 4'b0110);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_q", qa, ROT ? 4'b0110 : 4'b0000);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      valid = $urandom_range(0, 2) == 0;
      data_in = 4'($urandom);
      dir = 1'($urandom);
      stall = $urandom_range(0, 3) == 0;
      reset = $urandom_range(0, 80) != 0;
    end
    @(posedge clk); #1;
    reset = 1;
    valid = 0;
    stall = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
